fprint_collector: RTL

- Upstream neighbour of the fingerprint comparator.
- Accepts CRC fingerprint writes from up to 3 redundant cores, tagged with task ID and core ID, and stores one CRC per (task, core) slot.
- Raises a per-task checkin bit once every required core has reported that task, so the comparator can pick it up.
- Serves the three CRCs of the task the comparator has locked, and clears that task's slots on the comparator's reset-task handshake.

---
 rtl/fprint_collector_pkg.sv | 19 +
 rtl/fprint_slot_bank.sv | 96 +++++++++
 rtl/fprint_collector.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fprint_collector_pkg.sv
// Shared widths, core count and reset-task FSM encoding for the fingerprint collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fprint_collector_pkg;

    localparam int DEF_CRC_WIDTH    = 32;
    localparam int DEF_KEY_SIZE     = 16;
    localparam int DEF_KEY_WIDTH    = 4;
    localparam int FPRINT_NUM_CORES = 3;

    // Reset-task handshake states; encodings are shared with the comparator side.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEAR    = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_LOW = 2'd3
    } rst_fsm_t;

endpackage

// File: rtl/fprint_slot_bank.sv
// CRC slot array (task x core) with present bits, write/drop decision and registered readout.
// Latency: write visible in present 1 cycle after strobe; readout 1 cycle after task select.
// Backpressure: none; writes that cannot be stored are dropped and flagged on o_drop.
module fprint_slot_bank
    import fprint_collector_pkg::*;
#(
    parameter int CRC_WIDTH = DEF_CRC_WIDTH,
    parameter int KEY_SIZE  = DEF_KEY_SIZE,
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        i_wr_vld,
    input  logic [1:0]                                  i_wr_core,
    input  logic [KEY_WIDTH-1:0]                        i_wr_task,
    input  logic [CRC_WIDTH-1:0]                        i_wr_dat,
    input  logic [KEY_WIDTH-1:0]                        i_rd_task,
    input  logic                                        i_clr_vld,
    output logic [KEY_SIZE-1:0][FPRINT_NUM_CORES-1:0]   o_present,
    output logic [CRC_WIDTH-1:0]                        o_fp0,
    output logic [CRC_WIDTH-1:0]                        o_fp1,
    output logic [CRC_WIDTH-1:0]                        o_fp2,
    output logic                                        o_drop
);

    logic [KEY_SIZE-1:0][FPRINT_NUM_CORES-1:0] r_present;
    logic [CRC_WIDTH-1:0] r_slot [KEY_SIZE][FPRINT_NUM_CORES];
    logic [CRC_WIDTH-1:0] r_fp0, r_fp1, r_fp2;
    logic w_dup;
    logic w_core_ok;
    logic w_clr_hit;
    logic w_accept;

    // Duplicate report: the addressed slot already holds this iteration's CRC.
    always_comb begin
        w_dup = 1'b0;
        for (int c = 0; c < FPRINT_NUM_CORES; c++) begin
            if (i_wr_core == c[1:0] && r_present[i_wr_task][c]) begin
                w_dup = 1'b1;
            end
        end
    end

    assign w_core_ok = (i_wr_core < 2'(FPRINT_NUM_CORES));
    // A write racing the clear of the same task loses; it would otherwise be wiped anyway.
    assign w_clr_hit = i_clr_vld && (i_wr_task == i_rd_task);
    assign o_drop    = i_wr_vld && (!w_core_ok || w_dup || w_clr_hit);
    assign w_accept  = i_wr_vld && !o_drop;

    // Present bits: task clear has priority, otherwise an accepted write marks its slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_present <= '0;
        end else begin
            for (int t = 0; t < KEY_SIZE; t++) begin
                for (int c = 0; c < FPRINT_NUM_CORES; c++) begin
                    if (i_clr_vld && i_rd_task == KEY_WIDTH'(t)) begin
                        r_present[t][c] <= 1'b0;
                    end else if (w_accept && i_wr_task == KEY_WIDTH'(t) && i_wr_core == c[1:0]) begin
                        r_present[t][c] <= 1'b1;
                    end
                end
            end
        end
    end

    // CRC storage; contents are only meaningful while the matching present bit is set.
    always_ff @(posedge clk) begin
        for (int t = 0; t < KEY_SIZE; t++) begin
            for (int c = 0; c < FPRINT_NUM_CORES; c++) begin
                if (w_accept && i_wr_task == KEY_WIDTH'(t) && i_wr_core == c[1:0]) begin
                    r_slot[t][c] <= i_wr_dat;
                end
            end
        end
    end

    // Registered readout of the comparator's locked task.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fp0 <= '0;
            r_fp1 <= '0;
            r_fp2 <= '0;
        end else begin
            r_fp0 <= r_slot[i_rd_task][0];
            r_fp1 <= r_slot[i_rd_task][1];
            r_fp2 <= r_slot[i_rd_task][2];
        end
    end

    assign o_present = r_present;
    assign o_fp0     = r_fp0;
    assign o_fp1     = r_fp1;
    assign o_fp2     = r_fp2;

endmodule

// File: rtl/fprint_collector.sv
// Collects per-core CRC fingerprints per task, raises checkin, serves/clears the locked task.
// Latency: checkin 1 cycle after final write; readout 1 cycle; reset-task request to ack 2 cycles.
// Backpressure: none; dropped writes set sticky overrun (FPRINT_OVERRUN_COUNT_EN adds a drop counter).
module fprint_collector
    import fprint_collector_pkg::*;
#(
    parameter int CRC_WIDTH = DEF_CRC_WIDTH,
    parameter int KEY_SIZE  = DEF_KEY_SIZE,
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 comparator_nmr,
    input  logic                 fprint_write,
    input  logic [1:0]           fprint_core_id,
    input  logic [KEY_WIDTH-1:0] fprint_task_id,
    input  logic [CRC_WIDTH-1:0] fprint_data,
    input  logic [KEY_WIDTH-1:0] comparator_task_id,
    output logic [CRC_WIDTH-1:0] fprint_0,
    output logic [CRC_WIDTH-1:0] fprint_1,
    output logic [CRC_WIDTH-1:0] fprint_2,
    output logic [KEY_SIZE-1:0]  fprint_checkin,
    input  logic                 fprint_reset_task,
    output logic                 fprint_reset_task_ack,
    output logic                 overrun,
    input  logic                 overrun_clear
`ifdef FPRINT_OVERRUN_COUNT_EN
    ,
    output logic [7:0]           overrun_count
`endif
);

    rst_fsm_t r_state;
    rst_fsm_t w_state_nxt;
    logic     w_clr;
    logic     w_ack;
    logic     w_drop;
    logic     r_overrun;
    logic [KEY_SIZE-1:0][FPRINT_NUM_CORES-1:0] w_present;

    fprint_slot_bank #(
        .CRC_WIDTH (CRC_WIDTH),
        .KEY_SIZE  (KEY_SIZE),
        .KEY_WIDTH (KEY_WIDTH)
    ) u_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_vld  (fprint_write),
        .i_wr_core (fprint_core_id),
        .i_wr_task (fprint_task_id),
        .i_wr_dat  (fprint_data),
        .i_rd_task (comparator_task_id),
        .i_clr_vld (w_clr),
        .o_present (w_present),
        .o_fp0     (fprint_0),
        .o_fp1     (fprint_1),
        .o_fp2     (fprint_2),
        .o_drop    (w_drop)
    );

    // Reset-task FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: one clear and one ack per request; WAIT_LOW absorbs a lingering request level.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (fprint_reset_task) w_state_nxt = ST_CLEAR;
            ST_CLEAR:    w_state_nxt = ST_ACK;
            ST_ACK:      w_state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!fprint_reset_task) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        w_clr = (r_state == ST_CLEAR);
        w_ack = (r_state == ST_ACK);
    end

    assign fprint_reset_task_ack = w_ack;

    // Checkin: all required cores present; core 2 only gates in triple-modular mode.
    always_comb begin
        fprint_checkin = '0;
        for (int t = 0; t < KEY_SIZE; t++) begin
            fprint_checkin[t] = w_present[t][0] & w_present[t][1] & (w_present[t][2] | ~comparator_nmr);
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;

`ifdef FPRINT_OVERRUN_COUNT_EN
    logic [7:0] r_ovr_cnt;

    // Saturating drop counter; a drop coinciding with clear restarts the count at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr_cnt <= '0;
        end else if (overrun_clear) begin
            r_ovr_cnt <= {7'd0, w_drop};
        end else if (w_drop && r_ovr_cnt != 8'hFF) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign overrun_count = r_ovr_cnt;
`endif

endmodule
